pc_ras: RTL and testbench
=========================

# pc_ras

Parametrised program-counter unit for the pipelined core, successor to the single-width PC block. It holds the word-addressed fetch PC, resolves J/JAL in decode and conditional branches and JR in E1, and adds a return-address stack (RAS) that predicts JR targets in decode. It also has a selectable signed/unsigned branch compare and a sticky halt state. It sits between fetch and the decode/E1 stages and drives the instruction-memory address.

## Interface
- `AW`, 32: PC/operand width.
- `RAS_DEPTH`, 4: RAS entries, power of two, ≥2.
- `SIGNED_CMP`, 0: 1 makes BLT/BLE compare signed.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `op_d` in 6: opcode in decode.
- `addr_d` in 26: jump field in decode (byte address).
- `pc_d` in AW: PC of the decode instruction.
- `op_e` in 6: opcode in E1.
- `os_e`, `ot_e` in AW: source operands in E1.
- `imm_e` in AW: sign-extended byte displacement in E1.
- `pc_e` in AW: PC of the E1 instruction.
- `pc_out` out AW: fetch address.
- `stall_f` out 1: hold fetch/decode registers this cycle.
- `flush_d` out 1: squash the instruction entering decode next cycle.
- `flush_e` out 1: squash the instruction entering E1 next cycle.
- `halted` out 1: sticky halt.

## Operation
- Opcodes: BEQ 32, BNE 33, BLT 34, BLE 35, J 40, JAL 41, JR 42, LD-class stall 16/18/20, HALT 63.
- Next-PC priority, highest first. One source is selected per cycle.
  1. `halted`: PC holds at 0 and all outputs are frozen.
  2. `op_e`==63: `halted`<=1, PC<=0, `flush_d`=`flush_e`=1.
  3. E1 redirect:
     - A taken branch goes to `pc_e+1+(imm_e>>>2)` (arithmetic shift).
     - A JR with no valid prediction, or with `pred_tgt`!=`os_e`, goes to `os_e`.
     - Asserts `flush_d`=`flush_e`=1.
     - All decode-stage actions (push, pop, jump) are suppressed in that cycle.
  4. Decode redirect:
     - J/JAL go to `{0, addr_d>>2}`. JAL also pushes `pc_d+1`.
     - JR with the RAS non-empty pops the top, redirects to it, sets `pred_v`<=1 and `pred_tgt`<=popped value.
     - JR with the RAS empty: no redirect, `pred_v`<=0.
     - Any taken decode redirect asserts `flush_d`=1.
  5. `op_d` in {16,18,20}: `stall_f`=1 and PC holds for exactly one cycle. This is not re-asserted while the same instruction is held.
  6. Otherwise PC<=PC+1, wrapping modulo 2^AW.
- A JR in E1 with a correct prediction causes no redirect. `pred_v` clears whenever a JR leaves E1.
- RAS is circular with a `sp` pointer and a `count`, `count` saturating at `RAS_DEPTH`.
  - Push when full overwrites the oldest entry.
  - Pop when empty is not possible, because case 4 checks first.
- Branch compare: width AW. Unsigned unless `SIGNED_CMP`=1 (affects 34/35 only).

## Timing
- All state is updated on the rising edge of `clk`. Redirects appear on `pc_out` the cycle after the deciding inputs.
- `stall_f`, `flush_d` and `flush_e` are combinational from the current inputs and state.
- Reset (any cycle, including while halted or mid-stall) sets:
  - `pc_out`=0, `halted`=0, RAS `count`=0, `sp`=0, `pred_v`=0.
  - The stall one-shot is cleared.
  - While `rst` is high, flush/stall outputs are 0.
- Decode redirect penalty is 1 bubble. E1 redirect penalty is 2 bubbles. A correctly predicted JR has a penalty of 1.

## Structure
- Shared package `pc_pkg` holds the opcode localparams (32–35, 40–42, 16/18/20, 63) and a `next_pc_sel` enum (HALT, E1, DEC, STALL, SEQ).
- Sub-module `ras_stack`, parametrised by `AW` and `RAS_DEPTH`:
  - Ports: `push`, `pop`, `push_data`, `top`, `empty`, `full`.
  - Synchronous `rst`.
  - A simultaneous push and pop is illegal (assertion).

## Test plan
- Reset then 5 SEQ cycles: `pc_out` goes 0,1,2,3,4,5. All flags are 0.
- BEQ in E1 at `pc_e`=8, `imm_e`=16, `os_e`=`ot_e`: next `pc_out`=13, with `flush_d`/`flush_e` high. With `SIGNED_CMP`=1, BLT with `os_e`=-1 and `ot_e`=1 is taken. With `SIGNED_CMP`=0 it is not taken.
- JAL at `pc_d`=20, `addr_d`=0x100: `pc_out`=0x40, RAS top=21. A later JR in decode gives `pc_out`=21. In E1 with `os_e`=21 there is no redirect.
- Mispredicted JR (predicted 21, `os_e`=50): `pc_out`=50 with `flush_e`=1. A JAL in decode in the same cycle does not push; `count` is unchanged.
- `RAS_DEPTH`=4: JALs at `pc_d`=0..4 wrap the stack. Four JR pops return 5,4,3,2. A fifth JR is not predicted and resolves in E1.
- HALT in E1: `halted`=1 and `pc_out`=0 is held for 10 cycles regardless of inputs. Asserting `rst` clears `halted` and the next cycle `pc_out`=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared opcode constants and next-PC source encoding for the fetch PC unit.
package pc_pkg;

    localparam logic [5:0] OP_BEQ  = 6'd32;
    localparam logic [5:0] OP_BNE  = 6'd33;
    localparam logic [5:0] OP_BLT  = 6'd34;
    localparam logic [5:0] OP_BLE  = 6'd35;
    localparam logic [5:0] OP_J    = 6'd40;
    localparam logic [5:0] OP_JAL  = 6'd41;
    localparam logic [5:0] OP_JR   = 6'd42;
    localparam logic [5:0] OP_LD0  = 6'd16;
    localparam logic [5:0] OP_LD1  = 6'd18;
    localparam logic [5:0] OP_LD2  = 6'd20;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [2:0] {
        SEL_HALT,
        SEL_E1,
        SEL_DEC,
        SEL_STALL,
        SEL_SEQ
    } next_pc_sel;

    function automatic logic is_ld(input logic [5:0] op);
        return (op == OP_LD0) || (op == OP_LD1) || (op == OP_LD2);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned AW        = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int unsigned SPW = $clog2(RAS_DEPTH);

    logic [AW-1:0]  mem [RAS_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_top;
    logic [SPW:0]   count;

    assign sp_top = sp - SPW'(1);
    assign top    = mem[sp_top];
    assign empty  = (count == '0);
    assign full   = (count == (SPW+1)'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp <= sp + SPW'(1);
            if (!full)
                count <= count + (SPW+1)'(1);
        end else if (pop) begin
            sp    <= sp_top;
            count <= count - (SPW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[sp] <= push_data;
    end

    a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/pc_ras.sv
// Fetch PC unit: decode/E1 redirects, RAS-predicted JR, load-use stall one-shot, sticky halt.
module pc_ras #(
    parameter int unsigned AW         = 32,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned SIGNED_CMP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    op_d,
    input  logic [25:0]   addr_d,
    input  logic [AW-1:0] pc_d,
    input  logic [5:0]    op_e,
    input  logic [AW-1:0] os_e,
    input  logic [AW-1:0] ot_e,
    input  logic [AW-1:0] imm_e,
    input  logic [AW-1:0] pc_e,
    output logic [AW-1:0] pc_out,
    output logic          stall_f,
    output logic          flush_d,
    output logic          flush_e,
    output logic          halted
);

    import pc_pkg::*;

    logic [AW-1:0] pc_q;
    logic          halted_q;
    logic          stall_q;
    logic          pred_v;
    logic [AW-1:0] pred_tgt;

    logic          eq, lt, br_taken, jr_mispred, dec_taken;
    logic [AW-1:0] br_tgt, jmp_tgt, e1_tgt, dec_tgt;
    logic          ras_push, ras_pop, ras_empty, unused_ras_full;
    logic [AW-1:0] ras_top;
    next_pc_sel    sel;

    assign eq = (os_e == ot_e);
    assign lt = (SIGNED_CMP != 0) ? ($signed(os_e) < $signed(ot_e)) : (os_e < ot_e);

    always_comb begin
        case (op_e)
            OP_BEQ:  br_taken = eq;
            OP_BNE:  br_taken = !eq;
            OP_BLT:  br_taken = lt;
            OP_BLE:  br_taken = lt || eq;
            default: br_taken = 1'b0;
        endcase
    end

    assign br_tgt     = pc_e + AW'(1) + AW'($signed(imm_e) >>> 2);
    assign jr_mispred = (op_e == OP_JR) && !(pred_v && (pred_tgt == os_e));
    assign e1_tgt     = br_taken ? br_tgt : os_e;

    assign jmp_tgt   = AW'(addr_d >> 2);
    assign dec_taken = (op_d == OP_J) || (op_d == OP_JAL) || ((op_d == OP_JR) && !ras_empty);
    assign dec_tgt   = (op_d == OP_JR) ? ras_top : jmp_tgt;

    // One source per cycle; a frozen halt and an incoming HALT share the top slot.
    always_comb begin
        sel = SEL_SEQ;
        if (halted_q || (op_e == OP_HALT))
            sel = SEL_HALT;
        else if (br_taken || jr_mispred)
            sel = SEL_E1;
        else if (dec_taken)
            sel = SEL_DEC;
        else if (is_ld(op_d) && !stall_q)
            sel = SEL_STALL;
    end

    assign flush_e = !rst && !halted_q && ((sel == SEL_HALT) || (sel == SEL_E1));
    assign flush_d = flush_e || (!rst && (sel == SEL_DEC));
    assign stall_f = !rst && (sel == SEL_STALL);

    assign ras_push = !rst && (sel == SEL_DEC) && (op_d == OP_JAL);
    assign ras_pop  = !rst && (sel == SEL_DEC) && (op_d == OP_JR);

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_d + AW'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (unused_ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            stall_q  <= 1'b0;
            pred_v   <= 1'b0;
            pred_tgt <= '0;
        end else if (!halted_q) begin
            stall_q <= (sel == SEL_STALL);
            if (op_e == OP_JR)
                pred_v <= 1'b0;
            case (sel)
                SEL_HALT: begin
                    halted_q <= 1'b1;
                    pc_q     <= '0;
                end
                SEL_E1:    pc_q <= e1_tgt;
                SEL_DEC: begin
                    pc_q <= dec_tgt;
                    if (op_d == OP_JR) begin
                        pred_v   <= 1'b1;
                        pred_tgt <= ras_top;
                    end
                end
                SEL_STALL: pc_q <= pc_q;
                default: begin
                    pc_q <= pc_q + AW'(1);
                    // JR meeting an empty RAS leaves no prediction behind
                    if (op_d == OP_JR)
                        pred_v <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_ras;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op_d, op_e;
    logic [25:0] addr_d;
    logic [31:0] pc_d, os_e, ot_e, imm_e, pc_e;
    logic [31:0] pc_out, pc_out_s;
    logic        stall_f, flush_d, flush_e, halted;
    logic        stall_f_s, flush_d_s, flush_e_s, halted_s;

    always #5 clk = ~clk;

    pc_ras #(.AW(32), .RAS_DEPTH(D), .SIGNED_CMP(0)) dut (
        .clk(clk), .rst(rst), .op_d(op_d), .addr_d(addr_d), .pc_d(pc_d),
        .op_e(op_e), .os_e(os_e), .ot_e(ot_e), .imm_e(imm_e), .pc_e(pc_e),
        .pc_out(pc_out), .stall_f(stall_f), .flush_d(flush_d), .flush_e(flush_e), .halted(halted)
    );

    pc_ras #(.AW(32), .RAS_DEPTH(D), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst(rst), .op_d(op_d), .addr_d(addr_d), .pc_d(pc_d),
        .op_e(op_e), .os_e(os_e), .ot_e(ot_e), .imm_e(imm_e), .pc_e(pc_e),
        .pc_out(pc_out_s), .stall_f(stall_f_s), .flush_d(flush_d_s), .flush_e(flush_e_s), .halted(halted_s)
    );

    int passed = 0;
    int total  = 0;

    // Reference state for the unsigned-compare instance
    logic [31:0] m_pc;
    bit          m_halt, m_pv, m_stalled;
    logic [31:0] m_pt;
    logic [31:0] m_ras[$];
    logic [2:0]  exp_flags;            // {stall_f, flush_d, flush_e}
    logic [2:0]  obs_flags, obs_flags_s;

    task automatic model_step();
        bit taken;
        bit jr_mis;
        exp_flags = 3'b000;
        if (rst) begin
            m_pc = 0; m_halt = 0; m_pv = 0; m_stalled = 0;
            m_ras.delete();
            return;
        end
        if (m_halt) return;
        m_stalled = 0;
        if (op_e == 6'd63) begin
            exp_flags = 3'b011; m_halt = 1; m_pc = 0;
            return;
        end
        case (op_e)
            6'd32:   taken = (os_e == ot_e);
            6'd33:   taken = (os_e != ot_e);
            6'd34:   taken = (os_e <  ot_e);
            6'd35:   taken = (os_e <= ot_e);
            default: taken = 0;
        endcase
        jr_mis = (op_e == 6'd42) && !(m_pv && (m_pt == os_e));
        if (op_e == 6'd42) m_pv = 0;
        if (taken) begin
            m_pc = pc_e + 32'd1 + 32'($signed(imm_e) >>> 2);
            exp_flags = 3'b011;
            return;
        end
        if (jr_mis) begin
            m_pc = os_e;
            exp_flags = 3'b011;
            return;
        end
        if (op_d == 6'd40 || op_d == 6'd41) begin
            if (op_d == 6'd41) begin
                if (m_ras.size() == D) m_ras.delete(0);
                m_ras.push_back(pc_d + 32'd1);
            end
            m_pc = {6'b0, addr_d} >> 2;
            exp_flags = 3'b010;
            return;
        end
        if (op_d == 6'd42 && m_ras.size() > 0) begin
            m_pt = m_ras.pop_back();
            m_pv = 1;
            m_pc = m_pt;
            exp_flags = 3'b010;
            return;
        end
        if (op_d == 6'd42) m_pv = 0;
        if (op_d inside {6'd16, 6'd18, 6'd20}) begin
            m_stalled = 1;
            exp_flags = 3'b100;
            return;
        end
        m_pc = m_pc + 32'd1;
    endtask

    // Load-use one-shot: the model clears m_stalled each live cycle, so keep the previous value here
    bit prev_stalled;

    task automatic apply(input logic r, input logic [5:0] od, input logic [25:0] ad,
                         input logic [31:0] pd, input logic [5:0] oe, input logic [31:0] os,
                         input logic [31:0] ot, input logic [31:0] im, input logic [31:0] pe);
        rst = r; op_d = od; addr_d = ad; pc_d = pd;
        op_e = oe; os_e = os; ot_e = ot; imm_e = im; pc_e = pe;
        #3;
        obs_flags   = {stall_f, flush_d, flush_e};
        obs_flags_s = {stall_f_s, flush_d_s, flush_e_s};
        prev_stalled = m_stalled;
        if (!rst && !m_halt && prev_stalled && (od inside {6'd16, 6'd18, 6'd20})) begin
            // held load already stalled once: treat as a plain sequential cycle
            m_stalled = 0;
            op_d = 6'd0;
            model_step();
            op_d = od;
        end else begin
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        apply(r, 6'd0, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        idle(1'b1);
        idle(1'b1);
        total++; if (obs_flags !== 3'b000) $display("FAIL reset_flags: got %b want 000", obs_flags); else passed++;
        total++; if (pc_out !== 32'd0 || halted !== 1'b0) $display("FAIL reset_state: pc_out=%0d halted=%b want 0/0", pc_out, halted); else passed++;
        for (int unsigned i = 1; i <= 5; i++) begin
            idle(1'b0);
            total++;
            if (pc_out !== 32'(i) || obs_flags !== 3'b000 || halted !== 1'b0)
                $display("FAIL seq_%0d: pc_out=%0d flags=%b halted=%b want %0d/000/0", i, pc_out, obs_flags, halted, i);
            else passed++;
        end
    endtask

    task automatic test_branch();
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd32, 32'd7, 32'd7, 32'd16, 32'd8);
        total++; if (obs_flags !== 3'b011) $display("FAIL beq_flags: got %b want 011", obs_flags); else passed++;
        total++; if (pc_out !== 32'd13) $display("FAIL beq_target: pc_out=%0d want 13", pc_out); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd33, 32'd9, 32'd9, 32'd16, 32'd8);
        total++; if (pc_out !== 32'd14 || obs_flags !== 3'b000) $display("FAIL bne_not_taken: pc_out=%0d flags=%b want 14/000", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd33, 32'd1, 32'd2, 32'hFFFF_FFFA, 32'd100);
        total++; if (pc_out !== 32'd99) $display("FAIL bne_neg_disp: pc_out=%0d want 99", pc_out); else passed++;
    endtask

    task automatic test_signed_cmp();
        idle(1'b1);
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd34, 32'hFFFF_FFFF, 32'd1, 32'd16, 32'd8);
        total++; if (pc_out !== 32'd1 || obs_flags !== 3'b000) $display("FAIL blt_unsigned: pc_out=%0d flags=%b want 1/000", pc_out, obs_flags); else passed++;
        total++; if (pc_out_s !== 32'd13 || obs_flags_s !== 3'b011) $display("FAIL blt_signed: pc_out=%0d flags=%b want 13/011", pc_out_s, obs_flags_s); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd35, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd20);
        total++; if (pc_out !== 32'd21) $display("FAIL ble_unsigned: pc_out=%0d want 21", pc_out); else passed++;
        total++; if (pc_out_s !== 32'd14 || obs_flags_s !== 3'b000) $display("FAIL ble_signed: pc_out=%0d flags=%b want 14/000", pc_out_s, obs_flags_s); else passed++;
    endtask

    task automatic test_jal_jr();
        idle(1'b1);
        apply(1'b0, 6'd41, 26'h100, 32'd20, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'h40 || obs_flags !== 3'b010) $display("FAIL jal: pc_out=%0h flags=%b want 40/010", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd42, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd21 || obs_flags !== 3'b010) $display("FAIL jr_predict: pc_out=%0d flags=%b want 21/010", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd42, 32'd21, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd22 || obs_flags !== 3'b000) $display("FAIL jr_correct: pc_out=%0d flags=%b want 22/000", pc_out, obs_flags); else passed++;
    endtask

    task automatic test_mispredict();
        idle(1'b1);
        apply(1'b0, 6'd41, 26'h100, 32'd20, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        apply(1'b0, 6'd42, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        apply(1'b0, 6'd41, 26'h200, 32'd30, 6'd42, 32'd50, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd50 || obs_flags !== 3'b011) $display("FAIL jr_mispredict: pc_out=%0d flags=%b want 50/011", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd42, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd51 || obs_flags !== 3'b000) $display("FAIL no_push_on_redirect: pc_out=%0d flags=%b want 51/000", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd42, 32'd60, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd60 || obs_flags !== 3'b011) $display("FAIL jr_unpredicted: pc_out=%0d flags=%b want 60/011", pc_out, obs_flags); else passed++;
    endtask

    task automatic test_ras_wrap();
        idle(1'b1);
        for (int unsigned i = 0; i < 5; i++)
            apply(1'b0, 6'd41, 26'h400, 32'(i), 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'h100) $display("FAIL jal_chain: pc_out=%0h want 100", pc_out); else passed++;
        for (int unsigned k = 0; k < 4; k++) begin
            apply(1'b0, 6'd42, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            total++;
            if (pc_out !== 32'(5 - k) || obs_flags !== 3'b010)
                $display("FAIL ras_pop_%0d: pc_out=%0d flags=%b want %0d/010", k, pc_out, obs_flags, 5 - k);
            else passed++;
        end
        apply(1'b0, 6'd42, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd3 || obs_flags !== 3'b000) $display("FAIL ras_empty_jr: pc_out=%0d flags=%b want 3/000", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd0, 26'd0, 32'd0, 6'd42, 32'd77, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd77 || obs_flags !== 3'b011) $display("FAIL ras_empty_e1: pc_out=%0d flags=%b want 77/011", pc_out, obs_flags); else passed++;
    endtask

    task automatic test_stall();
        idle(1'b1);
        idle(1'b0);
        apply(1'b0, 6'd16, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd1 || obs_flags !== 3'b100) $display("FAIL ld_stall: pc_out=%0d flags=%b want 1/100", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd16, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd2 || obs_flags !== 3'b000) $display("FAIL ld_held: pc_out=%0d flags=%b want 2/000", pc_out, obs_flags); else passed++;
        apply(1'b0, 6'd18, 26'd0, 32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd2 || obs_flags !== 3'b100) $display("FAIL ld_next: pc_out=%0d flags=%b want 2/100", pc_out, obs_flags); else passed++;
    endtask

    task automatic test_halt();
        idle(1'b1);
        for (int unsigned i = 0; i < 3; i++) idle(1'b0);
        apply(1'b0, 6'd41, 26'h100, 32'd5, 6'd63, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd0 || halted !== 1'b1 || obs_flags !== 3'b011)
            $display("FAIL halt_enter: pc_out=%0d halted=%b flags=%b want 0/1/011", pc_out, halted, obs_flags);
        else passed++;
        for (int unsigned i = 0; i < 10; i++) begin
            apply(1'b0, 6'($urandom), 26'($urandom), $urandom, 6'($urandom_range(32, 42)), $urandom, $urandom, $urandom, $urandom);
            total++;
            if (pc_out !== 32'd0 || halted !== 1'b1 || obs_flags !== 3'b000)
                $display("FAIL halt_hold_%0d: pc_out=%0d halted=%b flags=%b want 0/1/000", i, pc_out, halted, obs_flags);
            else passed++;
        end
        apply(1'b1, 6'd41, 26'h100, 32'd5, 6'd63, 32'd0, 32'd0, 32'd0, 32'd0);
        total++; if (pc_out !== 32'd0 || halted !== 1'b0 || obs_flags !== 3'b000)
            $display("FAIL halt_reset: pc_out=%0d halted=%b flags=%b want 0/0/000", pc_out, halted, obs_flags);
        else passed++;
        idle(1'b0);
        total++; if (pc_out !== 32'd1) $display("FAIL halt_resume: pc_out=%0d want 1", pc_out); else passed++;
    endtask

    task automatic test_random();
        logic [5:0] od_tab [10] = '{6'd0, 6'd1, 6'd16, 6'd18, 6'd20, 6'd40, 6'd41, 6'd41, 6'd42, 6'd42};
        logic [5:0] oe_tab [8]  = '{6'd0, 6'd5, 6'd32, 6'd33, 6'd34, 6'd35, 6'd42, 6'd42};
        logic [5:0]  od, oe;
        logic [31:0] os;
        idle(1'b1);
        for (int unsigned n = 0; n < 400; n++) begin
            od = od_tab[$urandom_range(0, 9)];
            oe = oe_tab[$urandom_range(0, 7)];
            os = (oe == 6'd42 && $urandom_range(0, 1) == 1) ? m_pt : 32'($urandom_range(0, 3));
            apply(($urandom_range(0, 99) == 0), od, 26'($urandom), 32'($urandom_range(0, 1000)),
                  oe, os, 32'($urandom_range(0, 3)), 32'($signed($urandom_range(0, 200)) - 100),
                  32'($urandom_range(0, 1000)));
            total++;
            if (obs_flags !== exp_flags)
                $display("FAIL rand_flags_%0d: got %b want %b", n, obs_flags, exp_flags);
            else passed++;
            total++;
            if (pc_out !== m_pc || halted !== m_halt)
                $display("FAIL rand_pc_%0d: pc_out=%0d halted=%b want %0d/%b", n, pc_out, halted, m_pc, m_halt);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; op_d = '0; addr_d = '0; pc_d = '0;
        op_e = '0; os_e = '0; ot_e = '0; imm_e = '0; pc_e = '0;
        m_pc = '0; m_halt = 0; m_pv = 0; m_stalled = 0; m_pt = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_signed_cmp();
        test_jal_jr();
        test_mispredict();
        test_ras_wrap();
        test_stall();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
